// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-channel responder bridging AR/R handshakes to a req/ack peripheral read port.
// Optional macro AXI4_LITE_RD_RANGE_CHECK_EN: out-of-window addresses answer DECERR without a peripheral access.
module axi4_lite_read_slave #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH:0]    SIZE_BYTES     = (ADDR_WIDTH+1)'(32'h0000_1000),
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ack
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic             timeout_c;

  assign offset_c  = S_AXI_ARADDR - BASE_ADDR;
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef AXI4_LITE_RD_RANGE_CHECK_EN
  logic in_range_c;
  assign in_range_c = (S_AXI_ARADDR >= BASE_ADDR) && ({1'b0, offset_c} < SIZE_BYTES);
`else
  logic unused_size;
  assign unused_size = ^SIZE_BYTES;
`endif

  // Handshake/request strobes decode straight from the state register.
  assign S_AXI_ARREADY = (state == ST_IDLE);
  assign S_AXI_RVALID  = (state == ST_RESP);
  assign rd_req        = (state == ST_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rd_addr     <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (S_AXI_ARVALID) begin
            rd_addr <= offset_c;
            cnt     <= '0;
`ifdef AXI4_LITE_RD_RANGE_CHECK_EN
            if (!in_range_c) begin
              S_AXI_RDATA <= '0;
              S_AXI_RRESP <= RESP_DECERR;
              state       <= ST_RESP;
            end else begin
              state <= ST_REQ;
            end
`else
            state <= ST_REQ;
`endif
          end
        end
        ST_REQ: begin
          if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
          // Ack takes priority over a coincident timeout.
          if (rd_ack) begin
            S_AXI_RDATA <= rd_data;
            S_AXI_RRESP <= RESP_OKAY;
            state       <= ST_RESP;
          end else if (timeout_c) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_SLVERR;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (S_AXI_RREADY) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Directed bench for axi4_lite_read_slave (BASE 0x1000, SIZE 0x1000, timeout 4).
module tb_axi4_lite_read_slave;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_ack;

  int checks = 0;
  int errors = 0;

  axi4_lite_read_slave #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .BASE_ADDR      (32'h0000_1000),
    .SIZE_BYTES     (33'h0_0000_1000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an address for one cycle; returns just after the accepting edge.
  task automatic do_ar(input logic [31:0] addr);
    araddr  = addr;
    arvalid = 1'b1;
    check("arready_before_ar", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    rd_data = '0; rd_ack = 1'b0;
    tick(); tick();
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rdata",  rdata, 32'd0);
    check("rst_rresp",  32'(rresp), 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_arready", 32'(arready), 32'd1);

    // Zero-wait read
    do_ar(32'h0000_1008);
    check("zw_rd_req",  32'(rd_req), 32'd1);
    check("zw_rd_addr", rd_addr, 32'h0000_0008);
    check("zw_arready", 32'(arready), 32'd0);
    check("zw_rvalid_early", 32'(rvalid), 32'd0);
    rd_ack = 1'b1; rd_data = 32'hDEAD_BEEF;
    tick();
    rd_ack = 1'b0; rd_data = '0;
    check("zw_rvalid", 32'(rvalid), 32'd1);
    check("zw_rdata",  rdata, 32'hDEAD_BEEF);
    check("zw_rresp",  32'(rresp), 32'd0);
    check("zw_rd_req_low", 32'(rd_req), 32'd0);
    tick();
    check("zw_rvalid_done", 32'(rvalid), 32'd0);
    check("zw_arready_back", 32'(arready), 32'd1);

    // Backpressure: RREADY low for 5 cycles
    rready = 1'b0;
    do_ar(32'h0000_1010);
    check("bp_rd_addr", rd_addr, 32'h0000_0010);
    rd_ack = 1'b1; rd_data = 32'hA5A5_5A5A;
    tick();
    rd_ack = 1'b0; rd_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid",  32'(rvalid), 32'd1);
      check("bp_rdata",   rdata, 32'hA5A5_5A5A);
      check("bp_rresp",   32'(rresp), 32'd0);
      check("bp_arready", 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    check("bp_arready_back", 32'(arready), 32'd1);
    check("bp_rvalid_done",  32'(rvalid), 32'd0);

    // Timeout: no ack, rd_req for exactly 4 cycles
    rready = 1'b0;
    do_ar(32'h0000_1004);
    for (int i = 0; i < 4; i++) begin
      check("to_rd_req", 32'(rd_req), 32'd1);
      check("to_rvalid_low", 32'(rvalid), 32'd0);
      tick();
    end
    check("to_rvalid", 32'(rvalid), 32'd1);
    check("to_rresp",  32'(rresp), 32'd2);
    check("to_rdata",  rdata, 32'd0);
    check("to_rd_req_low", 32'(rd_req), 32'd0);
    rd_ack = 1'b1; rd_data = 32'hFFFF_FFFF;
    tick();
    rd_ack = 1'b0; rd_data = '0;
    check("to_late_ack_rdata", rdata, 32'd0);
    check("to_late_ack_rresp", 32'(rresp), 32'd2);
    check("to_late_ack_rvalid", 32'(rvalid), 32'd1);
    rready = 1'b1;
    tick();
    check("to_arready_back", 32'(arready), 32'd1);

    // Ack coincides with the timeout cycle: ack wins
    do_ar(32'h0000_1020);
    tick(); tick(); tick();
    check("col_rd_req_4th", 32'(rd_req), 32'd1);
    rd_ack = 1'b1; rd_data = 32'h1234_5678;
    tick();
    rd_ack = 1'b0; rd_data = '0;
    check("col_rvalid", 32'(rvalid), 32'd1);
    check("col_rresp",  32'(rresp), 32'd0);
    check("col_rdata",  rdata, 32'h1234_5678);
    tick();

    // Reset held 3 cycles in the middle of a request
    do_ar(32'h0000_1030);
    tick();
    check("mr_rd_req_before", 32'(rd_req), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_rvalid", 32'(rvalid), 32'd0);
      check("mr_rd_req", 32'(rd_req), 32'd0);
      check("mr_rdata",  rdata, 32'd0);
      check("mr_rresp",  32'(rresp), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("mr_arready", 32'(arready), 32'd1);
    check("mr_rd_addr", rd_addr, 32'd0);

`ifdef AXI4_LITE_RD_RANGE_CHECK_EN
    do_ar(32'h0000_2000);
    check("rc_rd_req",  32'(rd_req), 32'd0);
    check("rc_rvalid",  32'(rvalid), 32'd1);
    check("rc_rresp",   32'(rresp), 32'd3);
    check("rc_rdata",   rdata, 32'd0);
    tick();
    check("rc_arready", 32'(arready), 32'd1);
    do_ar(32'h0000_1FFC);
    check("rc_in_rd_req",  32'(rd_req), 32'd1);
    check("rc_in_rd_addr", rd_addr, 32'h0000_0FFC);
    rd_ack = 1'b1; rd_data = 32'h0BAD_F00D;
    tick();
    rd_ack = 1'b0;
    check("rc_in_rresp", 32'(rresp), 32'd0);
    check("rc_in_rdata", rdata, 32'h0BAD_F00D);
    tick();
`else
    // Without range checking the out-of-window address is still forwarded.
    do_ar(32'h0000_2000);
    check("nrc_rd_req",  32'(rd_req), 32'd1);
    check("nrc_rd_addr", rd_addr, 32'h0000_1000);
    rd_ack = 1'b1; rd_data = 32'h0BAD_F00D;
    tick();
    rd_ack = 1'b0;
    check("nrc_rresp", 32'(rresp), 32'd0);
    check("nrc_rdata", rdata, 32'h0BAD_F00D);
    tick();
`endif
    check("end_arready", 32'(arready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_read_slave.md
# axi4_lite_read_slave

AXI4-Lite read-channel responder: accepts read addresses from an AXI4-Lite master (e.g. the core's read master), issues one request on a simple peripheral read port, and returns the data with a response code. It sits between the SoC interconnect and a memory-mapped peripheral or data RAM, converting the AR/R handshakes into a req/ack port that may stall for a variable number of cycles. A wait-state timeout guarantees every accepted address gets a response.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- BASE_ADDR, 32'h0000_0000, base of this slave's address window; subtracted from ARADDR to form rd_addr
- SIZE_BYTES, 32'h0000_1000, window size in bytes (used only with range check)
- TIMEOUT_CYCLES, 16, max REQ-state cycles before SLVERR; 0 = wait forever
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  address valid
- S_AXI_ARREADY  out  1  slave accepts address
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  master accepts data
- rd_req  out  1  peripheral read request, held until rd_ack
- rd_addr  out  ADDR_WIDTH  peripheral address = ARADDR − BASE_ADDR (mod 2^ADDR_WIDTH)
- rd_data  in  DATA_WIDTH  peripheral data, valid when rd_ack=1
- rd_ack  in  1  peripheral completion strobe

## Operation
- States: ST_IDLE, ST_REQ, ST_RESP (2-bit encoding).
- ST_IDLE: ARREADY=1. On ARVALID&ARREADY: latch rd_addr = ARADDR − BASE_ADDR, clear timeout counter, go ST_REQ (or ST_RESP with DECERR, see Configuration).
- ST_REQ: rd_req=1, rd_addr stable. Counter increments each cycle. If rd_ack=1: register RDATA=rd_data, RRESP=00, go ST_RESP. Else if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES−1: RDATA=0, RRESP=10, go ST_RESP. rd_ack and timeout in same cycle: ack wins (OKAY).
- ST_RESP: RVALID=1; RDATA/RRESP held stable until RREADY=1, then go ST_IDLE. RVALID never drops without RREADY.
- ARREADY=0 outside ST_IDLE; one transaction outstanding at most.
- rd_ack outside ST_REQ ignored; rd_data sampled only in ST_REQ with rd_ack.
- Counter width $clog2(TIMEOUT_CYCLES+1), saturating; unused when TIMEOUT_CYCLES=0.
- Reset (any state, mid-transaction included): state ST_IDLE, RVALID=0, RDATA=0, RRESP=00, rd_req=0, rd_addr=0, counter=0; pending transaction dropped. ARREADY=1 from first cycle after reset deasserts.

## Timing
- All outputs registered or decoded from state register only; no combinational path from AXI inputs to AXI outputs.
- AR handshake at edge N → rd_req high in cycle N+1.
- rd_ack sampled at edge N+k (k≥1) → RVALID high from cycle N+k+1.
- Minimum latency AR handshake to RVALID: 2 cycles (zero-wait peripheral).
- R handshake at edge M → ARREADY high in cycle M+1; back-to-back throughput 1 read per 3 cycles minimum.
- Timeout: ack never arrives → RVALID with SLVERR in cycle N+TIMEOUT_CYCLES+1.

## Configuration
- Macro AXI4_LITE_RD_RANGE_CHECK_EN.
- Defined: at AR handshake, address outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES) skips ST_REQ, goes straight to ST_RESP with RRESP=11, RDATA=0; rd_req never asserts (RVALID in cycle N+1). In-range addresses behave normally.
- Not defined: no range comparison; every address forwarded to peripheral; SIZE_BYTES ignored.

## Test plan
- Reset: assert rst 3 cycles mid-ST_REQ → RVALID=0, rd_req=0, RDATA=0, RRESP=00; next cycle ARREADY=1.
- Zero-wait read: BASE_ADDR=0x1000, ARADDR=0x1008, rd_ack same cycle rd_req rises, rd_data=0xDEADBEEF → rd_addr=0x0008, RVALID 2 cycles after AR handshake, RDATA=0xDEADBEEF, RRESP=00.
- Backpressure: RREADY low 5 cycles → RVALID, RDATA, RRESP stable all 5 cycles; ARREADY=0 throughout; ARREADY=1 cycle after RREADY.
- Timeout: TIMEOUT_CYCLES=4, rd_ack never → rd_req high exactly 4 cycles, then RVALID with RRESP=10, RDATA=0; late rd_ack in ST_RESP ignored.
- Ack/timeout collision: rd_ack=1 with rd_data=0x12345678 in 4th REQ cycle → RRESP=00, RDATA=0x12345678.
- Range check (macro defined, BASE 0x1000, SIZE 0x1000): ARADDR=0x2000 → rd_req stays 0, RVALID next cycle, RRESP=11; ARADDR=0x1FFC → normal OKAY read.
